// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter slice.
package eth_pkg;

  typedef enum logic [1:0] {
    ETH_ARB_IDLE = 2'd0,
    ETH_ARB_FWD  = 2'd1,
    ETH_ARB_DROP = 2'd2
  } eth_arb_state_t;

  localparam int ETH_MAX_FRAME_LEN_DEFAULT = 1522;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin pick: first requesting port after 'last', wrapping.
module eth_rr_pick #(
  parameter int PORTS = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [1:0]       last,
  output logic             found,
  output logic [1:0]       idx
);

  logic hit;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    hit   = 1'b0;
    for (int i = 1; i <= PORTS; i++) begin
      hit = ((req >> ((int'(last) + i) % PORTS)) & PORTS'(1)) != '0;
      if (!found && hit) begin
        found = 1'b1;
        idx   = 2'((int'(last) + i) % PORTS);
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter merging several AXI-stream byte sources
// into one MAC TX stream, truncating frames that exceed MAX_FRAME_LEN.
module eth_tx_frame_arbiter
  import eth_pkg::*;
#(
  parameter int PORTS         = 2,
  parameter int MAX_FRAME_LEN = ETH_MAX_FRAME_LEN_DEFAULT
) (
  input  logic               logic_clk,
  input  logic               logic_rst_n,
  input  logic [PORTS*8-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]   s_axis_tvalid,
  input  logic [PORTS-1:0]   s_axis_tlast,
  input  logic [PORTS-1:0]   s_axis_tuser,
  output logic [PORTS-1:0]   s_axis_tready,
  input  logic [PORTS-1:0]   port_en,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  input  logic               m_axis_tready,
  output logic [1:0]         grant_idx,
  output logic               frame_done,
  output logic               frame_trunc
);

  localparam logic [11:0] MAX_LEN   = 12'(MAX_FRAME_LEN);
  localparam logic [1:0]  LAST_PORT = 2'(PORTS - 1);

  eth_arb_state_t   state;
  logic [1:0]       grant;
  logic [1:0]       last_grant;
  logic [11:0]      byte_cnt;
  logic [PORTS-1:0] grant_oh;
  logic [PORTS-1:0] arb_req;
  logic             out_ok;
  logic             sel_valid;
  logic             sel_last;
  logic             sel_user;
  logic [7:0]       sel_data;
  logic             pick_found;
  logic [1:0]       pick_idx;

  // Everything about the granted source is read through a one-hot mask so
  // that the port count never has to match the grant index width.
  assign grant_oh  = PORTS'(1) << grant;
  assign sel_valid = |(s_axis_tvalid & grant_oh);
  assign sel_last  = |(s_axis_tlast & grant_oh);
  assign sel_user  = |(s_axis_tuser & grant_oh);
  assign sel_data  = 8'(s_axis_tdata >> {grant, 3'b000});
  assign arb_req   = s_axis_tvalid & port_en;
  assign out_ok    = !m_axis_tvalid || m_axis_tready;

  eth_rr_pick #(.PORTS(PORTS)) u_rr_pick (
    .req   (arb_req),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    s_axis_tready = '0;
    case (state)
      ETH_ARB_FWD:  s_axis_tready = out_ok ? grant_oh : '0;
      ETH_ARB_DROP: s_axis_tready = grant_oh;
      default:      s_axis_tready = '0;
    endcase
  end

  assign grant_idx  = (state == ETH_ARB_IDLE) ? last_grant : grant;
  assign frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      state         <= ETH_ARB_IDLE;
      grant         <= LAST_PORT;
      last_grant    <= LAST_PORT;
      byte_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_trunc   <= 1'b0;
    end else begin
      frame_trunc <= 1'b0;
      if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        ETH_ARB_IDLE: begin
          if (pick_found) begin
            grant    <= pick_idx;
            byte_cnt <= '0;
            state    <= ETH_ARB_FWD;
          end
        end
        ETH_ARB_FWD: begin
          if (sel_valid && out_ok) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            byte_cnt      <= byte_cnt + 12'd1;
            // A real tlast at the length limit is a clean end, not a truncation.
            if (sel_last) begin
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= sel_user;
              last_grant   <= grant;
              state        <= ETH_ARB_IDLE;
            end else if (byte_cnt + 12'd1 == MAX_LEN) begin
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= 1'b1;
              frame_trunc  <= 1'b1;
              state        <= ETH_ARB_DROP;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= sel_user;
            end
          end
        end
        ETH_ARB_DROP: begin
          if (sel_valid && sel_last) begin
            last_grant <= grant;
            state      <= ETH_ARB_IDLE;
          end
        end
        default: state <= ETH_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized directed bench for eth_tx_frame_arbiter against a frame-level model.
module tb_eth_tx_frame_arbiter;

  localparam int PORTS   = 2;
  localparam int MAX_LEN = 64;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       first;
  } src_beat_t;
  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic [1:0] port;
    int         cyc;
  } out_beat_t;

  logic               logic_clk;
  logic               logic_rst_n;
  logic [PORTS*8-1:0] s_axis_tdata;
  logic [PORTS-1:0]   s_axis_tvalid;
  logic [PORTS-1:0]   s_axis_tlast;
  logic [PORTS-1:0]   s_axis_tuser;
  logic [PORTS-1:0]   s_axis_tready;
  logic [PORTS-1:0]   port_en;
  logic [7:0]         m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tuser;
  logic               m_axis_tready;
  logic [1:0]         grant_idx;
  logic               frame_done;
  logic               frame_trunc;

  src_beat_t src_q[PORTS][$];
  out_beat_t out_q[$];
  out_beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int trunc_cnt = 0;
  int start_cyc[PORTS];
  bit gap_en = 1'b0;
  bit rand_ready = 1'b0;
  int model_last = PORTS - 1;

  eth_tx_frame_arbiter #(.PORTS(PORTS), .MAX_FRAME_LEN(MAX_LEN)) dut (
    .logic_clk     (logic_clk),
    .logic_rst_n   (logic_rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .port_en       (port_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .grant_idx     (grant_idx),
    .frame_done    (frame_done),
    .frame_trunc   (frame_trunc)
  );

  initial logic_clk = 1'b0;
  always #5 logic_clk = ~logic_clk;

  initial forever begin
    @(posedge logic_clk);
    cyc++;
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge logic_clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Sources hold tvalid/data until the handshake seen at the preceding negedge.
  initial begin : src_driver
    bit hs [PORTS];
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    forever begin
      @(negedge logic_clk);
      for (int p = 0; p < PORTS; p++)
        hs[p] = logic_rst_n && s_axis_tvalid[p] && s_axis_tready[p];
      @(posedge logic_clk);
      #1;
      for (int p = 0; p < PORTS; p++) begin
        if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() == 0) begin
          s_axis_tvalid[p] = 1'b0;
        end else if (!s_axis_tvalid[p] || hs[p]) begin
          if (gap_en && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid[p] = 1'b0;
          end else begin
            s_axis_tvalid[p]       = 1'b1;
            s_axis_tdata[8*p +: 8] = src_q[p][0].data;
            s_axis_tlast[p]        = src_q[p][0].last;
            s_axis_tuser[p]        = src_q[p][0].user;
            if (src_q[p][0].first) start_cyc[p] = cyc;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge logic_clk);
    if (logic_rst_n) begin
      if (m_axis_tvalid && m_axis_tready)
        out_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser, grant_idx, cyc});
      if (frame_done) done_cnt++;
      if (frame_trunc) trunc_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_frame(input int p, input int len, input logic user_last, output byte_q_t bytes);
    logic [7:0] v;
    bytes = {};
    for (int i = 0; i < len; i++) begin
      v = 8'($urandom_range(0, 255));
      bytes.push_back(v);
      src_q[p].push_back('{v, (i == len - 1), (i == len - 1) ? user_last : 1'b0, (i == 0)});
    end
  endtask

  // Frame-level reference: clip to MAX_LEN, marking a clipped frame with tuser.
  function automatic void model_frame(input int p, input byte_q_t bytes, input logic user_last);
    int  n     = bytes.size();
    bit  trunc = n > MAX_LEN;
    int  outn  = trunc ? MAX_LEN : n;
    out_beat_t b;
    for (int i = 0; i < outn; i++) begin
      b.data = bytes[i];
      b.last = (i == outn - 1);
      b.user = (i == outn - 1) ? (trunc ? 1'b1 : user_last) : 1'b0;
      b.port = 2'(p);
      b.cyc  = 0;
      exp_q.push_back(b);
    end
  endfunction

  task automatic wait_beats(input int n, input string tag, input int settle);
    int k = 0;
    while (out_q.size() < n && k < 3000) begin
      @(posedge logic_clk);
      k++;
    end
    check({tag, "_beats_arrived"}, 32'(out_q.size() >= n), 32'd1);
    repeat (settle) @(posedge logic_clk);
    #1;
  endtask

  task automatic compare_stream(input string tag, input bit chk_port);
    int n;
    check({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(out_q[i].data), 32'(exp_q[i].data));
      check($sformatf("%s_last%0d", tag, i), 32'(out_q[i].last), 32'(exp_q[i].last));
      check($sformatf("%s_user%0d", tag, i), 32'(out_q[i].user), 32'(exp_q[i].user));
      if (chk_port)
        check($sformatf("%s_grant%0d", tag, i), 32'(out_q[i].port), 32'(exp_q[i].port));
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_m_tlast"}, 32'(m_axis_tlast), 32'd0);
    check({tag, "_m_tuser"}, 32'(m_axis_tuser), 32'd0);
    check({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
    check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_trunc"}, 32'(frame_trunc), 32'd0);
    check({tag, "_grant_idx"}, 32'(grant_idx), 32'(PORTS - 1));
  endtask

  initial begin : main
    byte_q_t fr, fa, fb, fc, fd;
    byte_q_t f33 [PORTS][3];
    int idx33 [PORTS];
    int rr_last, p, lat;
    bit picked;

    logic_rst_n = 1'b0;
    port_en     = '1;
    repeat (3) @(posedge logic_clk);
    @(negedge logic_clk);
    check_reset_outputs("reset_held");
    @(posedge logic_clk);
    #1 logic_rst_n = 1'b1;
    @(negedge logic_clk);
    check_reset_outputs("reset_released");

    // Single 3-byte frame from port 0, first byte two cycles after tvalid.
    @(posedge logic_clk);
    #1;
    done_cnt = 0; trunc_cnt = 0;
    make_frame(0, 3, 1'b0, fr);
    model_frame(0, fr, 1'b0);
    model_last = 0;
    wait_beats(3, "short", 6);
    lat = (out_q.size() > 0) ? out_q[0].cyc - start_cyc[0] : -1;
    check("short_latency", 32'(lat), 32'd2);
    check("short_done_cnt", 32'(done_cnt), 32'd1);
    check("short_trunc_cnt", 32'(trunc_cnt), 32'd0);
    compare_stream("short", 1'b1);

    // Both ports loaded with three 10-byte frames: whole frames, round-robin.
    done_cnt = 0; trunc_cnt = 0;
    for (int q = 0; q < PORTS; q++)
      for (int f = 0; f < 3; f++) make_frame(q, 10, 1'b0, f33[q][f]);
    rr_last = model_last;
    idx33 = '{default: 0};
    while (idx33[0] < 3 || idx33[1] < 3) begin
      picked = 1'b0;
      for (int k = 1; k <= PORTS; k++) begin
        p = (rr_last + k) % PORTS;
        if (!picked && idx33[p] < 3) begin
          model_frame(p, f33[p][idx33[p]], 1'b0);
          idx33[p]++;
          rr_last = p;
          picked  = 1'b1;
        end
      end
    end
    model_last = rr_last;
    wait_beats(60, "rr", 6);
    check("rr_done_cnt", 32'(done_cnt), 32'd6);
    compare_stream("rr", 1'b1);

    // Oversize frame truncated at MAX_LEN, remainder absorbed, next frame clean.
    done_cnt = 0; trunc_cnt = 0;
    make_frame(0, 100, 1'b0, fa);
    make_frame(0, 5, 1'b0, fb);
    model_frame(0, fa, 1'b0);
    model_frame(0, fb, 1'b0);
    model_last = 0;
    wait_beats(69, "trunc", 6);
    check("trunc_trunc_cnt", 32'(trunc_cnt), 32'd1);
    check("trunc_done_cnt", 32'(done_cnt), 32'd2);
    check("trunc_src_drained", 32'(src_q[0].size()), 32'd0);
    compare_stream("trunc", 1'b1);

    // Length boundary: exactly MAX_LEN passes clean (tuser carried), MAX_LEN+1 clips.
    done_cnt = 0; trunc_cnt = 0;
    make_frame(0, 64, 1'b0, fa);
    make_frame(0, 64, 1'b1, fb);
    make_frame(0, 65, 1'b0, fc);
    model_frame(0, fa, 1'b0);
    model_frame(0, fb, 1'b1);
    model_frame(0, fc, 1'b0);
    wait_beats(192, "edge", 6);
    check("edge_trunc_cnt", 32'(trunc_cnt), 32'd1);
    check("edge_done_cnt", 32'(done_cnt), 32'd3);
    compare_stream("edge", 1'b1);

    // Backpressure + source gaps; port 0 disabled mid-frame must still finish.
    done_cnt = 0; trunc_cnt = 0;
    rand_ready = 1'b1;
    gap_en     = 1'b1;
    make_frame(0, 40, 1'b0, fa);
    wait_beats(3, "en_start", 0);
    port_en[0] = 1'b0;
    make_frame(1, 8, 1'b0, fb);
    make_frame(1, 12, 1'b1, fc);
    make_frame(0, 6, 1'b0, fd);
    model_frame(0, fa, 1'b0);
    model_frame(1, fb, 1'b0);
    model_frame(1, fc, 1'b1);
    wait_beats(60, "en_off", 10);
    check("en_off_port0_pending", 32'(src_q[0].size()), 32'd6);
    compare_stream("en_off", 1'b0);
    port_en[0] = 1'b1;
    model_frame(0, fd, 1'b0);
    model_last = 0;
    wait_beats(6, "en_on", 10);
    check("en_done_cnt", 32'(done_cnt), 32'd4);
    compare_stream("en_on", 1'b0);
    rand_ready = 1'b0;
    gap_en     = 1'b0;
    repeat (2) @(posedge logic_clk);
    #1;

    // One-cycle reset in the middle of a frame.
    make_frame(0, 20, 1'b0, fa);
    wait_beats(5, "rst_mid", 0);
    logic_rst_n = 1'b0;
    src_q[0].delete();
    src_q[1].delete();
    @(posedge logic_clk);
    #1 logic_rst_n = 1'b1;
    @(negedge logic_clk);
    check_reset_outputs("rst_mid");
    out_q.delete();
    exp_q.delete();
    done_cnt = 0; trunc_cnt = 0;
    model_last = PORTS - 1;
    @(posedge logic_clk);
    #1;
    make_frame(0, 4, 1'b0, fb);
    model_frame(0, fb, 1'b0);
    wait_beats(4, "after_rst", 6);
    check("after_rst_done_cnt", 32'(done_cnt), 32'd1);
    compare_stream("after_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 Parameter PORTS, default 2, number of AXI-stream requesters (2..4).
REQ-002 Parameter MAX_FRAME_LEN, default 1522, maximum bytes forwarded per frame (64..4095).
REQ-003 logic_clk  in  1  sole clock; all logic rising-edge.
REQ-004 logic_rst_n  in  1  reset, synchronous, active-low.
REQ-005 s_axis_tdata  in  PORTS*8  per-port byte, port p at bits [8p+7:8p].
REQ-006 s_axis_tvalid / s_axis_tlast / s_axis_tuser  in  PORTS each  per-port stream sideband.
REQ-007 s_axis_tready  out  PORTS  per-port accept.
REQ-008 port_en  in  PORTS  per-port arbitration enable.
REQ-009 m_axis_tdata  out  8 / m_axis_tvalid, m_axis_tlast, m_axis_tuser  out  1 / m_axis_tready  in  1: stream to MAC TX FIFO.
REQ-010 grant_idx  out  2  currently or last granted port.
REQ-011 frame_done  out  1  one-cycle pulse per output frame completed (tlast accepted at output).
REQ-012 frame_trunc  out  1  one-cycle pulse when a frame is truncated.

Function
REQ-013 Arbitration SHALL be frame-granular: once granted, a port owns the output until its tlast is consumed.
REQ-014 States IDLE, FWD, DROP; reset state IDLE.
REQ-015 IDLE: pick first port p with s_axis_tvalid[p] & port_en[p], searching round-robin from last_grant+1 (mod PORTS); if found, latch grant, clear byte count, go FWD next cycle; otherwise stay IDLE.
REQ-016 IDLE SHALL assert no s_axis_tready bit (one-cycle arbitration bubble per frame).
REQ-017 Output stage SHALL be one register: accept condition out_ok = !m_axis_tvalid | m_axis_tready; FWD drives s_axis_tready[grant] = out_ok, all other bits 0.
REQ-018 Accepted byte appears on m_axis_* the following cycle (latency 1); m_axis_tvalid held with stable data until m_axis_tready.
REQ-019 Byte counter (12 bits) increments per accepted byte in FWD.
REQ-020 FWD, accepted byte with tlast: forward tlast/tuser unchanged, last_grant <= grant, go IDLE.
REQ-021 FWD, accepted byte without tlast where count+1 == MAX_FRAME_LEN: forward with tlast=1, tuser=1, pulse frame_trunc, go DROP.
REQ-022 Accepted byte with tlast exactly at MAX_FRAME_LEN SHALL be treated per REQ-020 (no truncation).
REQ-023 DROP: s_axis_tready[grant]=1 unconditionally, bytes discarded; on tlast go IDLE, last_grant <= grant.
REQ-024 frame_done pulses in the cycle m_axis_tvalid & m_axis_tready & m_axis_tlast.
REQ-025 Deasserting port_en[grant] mid-frame SHALL NOT abort the frame.
REQ-026 Source tvalid gaps in FWD SHALL be tolerated; m_axis_tvalid drops after the register drains.
REQ-027 grant_idx SHALL equal latched grant in FWD/DROP, last_grant in IDLE.

Reset
REQ-028 On logic_rst_n low at a clock edge: state IDLE, last_grant PORTS-1 (so port 0 wins first), count 0, m_axis_tvalid/tlast/tuser 0, m_axis_tdata 0, s_axis_tready 0, pulses 0, grant_idx PORTS-1.
REQ-029 Reset mid-frame SHALL discard the in-flight output byte; no partial-frame completion is emitted.

Structure
REQ-030 Shared package eth_pkg SHALL hold the state enum (ETH_ARB_IDLE/FWD/DROP) and default MAX_FRAME_LEN constant.
REQ-031 Round-robin selection SHALL be a combinational sub-module eth_rr_pick (req, last, -> found, idx).

Verification
REQ-032 Port0 sends 3-byte frame A,B,C, m_axis_tready=1 -> output A,B,C with tlast on C, tuser 0, first byte 2 cycles after tvalid, one frame_done.
REQ-033 Both ports hold 10-byte frames continuously -> output alternates port0,port1,port0,... whole frames, no interleaved bytes, grant_idx tracks.
REQ-034 MAX_FRAME_LEN=64, port0 sends 100-byte frame -> 64 bytes out, byte 64 tlast=1 tuser=1, frame_trunc once, remaining 36 bytes absorbed, next frame clean.
REQ-035 Exactly 64-byte frame with MAX_FRAME_LEN=64 -> tuser 0, no frame_trunc.
REQ-036 m_axis_tready toggled 1/0 random, port_en[0] dropped mid-frame -> byte order intact, frame completes, port0 not granted again until re-enabled.
REQ-037 logic_rst_n low for 1 cycle mid-frame -> next cycle all outputs at REQ-028 values; following frame from port0 forwarded correctly.
